// File: rtl/cpu_reg_file_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: read ports, write port and
// pending-write marks. Decode and writeback use the master modport; the register file uses slave.
interface cpu_reg_file_sb_if #(
  parameter int XLEN       = 32,
  parameter int READ_PORTS = 2
);
  logic                         ready;
  logic [5*READ_PORTS-1:0]      addr_rd;
  logic [XLEN*READ_PORTS-1:0]   data_rd;
  logic [READ_PORTS-1:0]        busy_rd;
  logic                         wr;
  logic [4:0]                   addr_wr;
  logic [XLEN-1:0]              data_wr;
  logic                         mark;
  logic [4:0]                   addr_mark;

  modport master (
    input  ready, data_rd, busy_rd,
    output addr_rd, wr, addr_wr, data_wr, mark, addr_mark
  );

  modport slave (
    output ready, data_rd, busy_rd,
    input  addr_rd, wr, addr_wr, data_wr, mark, addr_mark
  );
endinterface

// File: rtl/cpu_reg_file_sb.sv
// Register file with post-reset hardware clear, per-register pending-write scoreboard and
// combinational read ports. Define CPU_REG_FILE_BYPASS_EN for same-cycle write-to-read bypass.
module cpu_reg_file_sb #(
  parameter int XLEN           = 32,
  parameter bit MORE_REGISTERS = 1'b1,
  parameter int READ_PORTS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  cpu_reg_file_sb_if.slave  bus
);

  localparam int REG_COUNT = MORE_REGISTERS ? 32 : 16;
  localparam int IDX_W     = MORE_REGISTERS ? 5 : 4;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             ptr_q, ptr_d;
  logic                   clr_we;
  logic [XLEN-1:0]        regs [REG_COUNT];
  logic [REG_COUNT-1:0]   pending_q;
  logic                   run;
  logic                   wr_ok;
  logic                   mark_ok;

  // x0 is hardwired zero; addresses beyond the configured count do not exist.
  function automatic logic addr_valid(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < REG_COUNT);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [4:0] a);
    return a[IDX_W-1:0];
  endfunction

  assign run     = (state_q == S_RUN);
  assign wr_ok   = run && bus.wr   && addr_valid(bus.addr_wr);
  assign mark_ok = run && bus.mark && addr_valid(bus.addr_mark);
  assign bus.ready = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        if (int'(ptr_q) == REG_COUNT - 1) state_d = S_RUN;
        else                              ptr_d   = ptr_q + 5'd1;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = 5'd1;
      end
    endcase
  end

  // Storage has no reset; the clear walk zeroes x1..x(N-1) one per cycle.
  always_ff @(posedge clk) begin
    if (clr_we)     regs[to_idx(ptr_q)]       <= '0;
    else if (wr_ok) regs[to_idx(bus.addr_wr)] <= bus.data_wr;
  end

  // Mark is applied after the write so a same-edge write+mark leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      if (wr_ok)   pending_q[to_idx(bus.addr_wr)]   <= 1'b0;
      if (mark_ok) pending_q[to_idx(bus.addr_mark)] <= 1'b1;
    end
  end

  always_comb begin
    bus.data_rd = '0;
    bus.busy_rd = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if (run && addr_valid(bus.addr_rd[5*i +: 5])) begin
        bus.data_rd[XLEN*i +: XLEN] = regs[to_idx(bus.addr_rd[5*i +: 5])];
        bus.busy_rd[i]              = pending_q[to_idx(bus.addr_rd[5*i +: 5])];
`ifdef CPU_REG_FILE_BYPASS_EN
        if (wr_ok && (bus.addr_rd[5*i +: 5] == bus.addr_wr)) begin
          bus.data_rd[XLEN*i +: XLEN] = bus.data_wr;
          bus.busy_rd[i]              = mark_ok && (bus.addr_mark == bus.addr_wr);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_reg_file_sb.sv
// Directed bench for cpu_reg_file_sb: a 32-register/4-port instance and a 16-register/1-port instance.
module tb_cpu_reg_file_sb;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   e0, e1;
  logic bad;

`ifdef CPU_REG_FILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP   = 32'h55;
  localparam logic        BUSY7_EXP = 1'b0;
`else
  localparam logic [31:0] BYP_EXP   = 32'h11;
  localparam logic        BUSY7_EXP = 1'b1;
`endif

  always #5 clk = ~clk;

  cpu_reg_file_sb_if #(.XLEN(32), .READ_PORTS(4)) b0 ();
  cpu_reg_file_sb_if #(.XLEN(32), .READ_PORTS(1)) b1 ();

  cpu_reg_file_sb #(.XLEN(32), .MORE_REGISTERS(1'b1), .READ_PORTS(4)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  cpu_reg_file_sb #(.XLEN(32), .MORE_REGISTERS(1'b0), .READ_PORTS(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until each instance reports ready; flags any nonzero read during the clear.
  task automatic wait_ready(output int n32, output int n16, output logic any_bad);
    n32 = 0;
    n16 = 0;
    any_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n16 == 0 && b1.ready) n16 = n;
      if (b0.ready) begin
        n32 = n;
        break;
      end
      if (b0.data_rd != '0 || b0.busy_rd != '0) any_bad = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    b0.addr_rd = '0; b0.wr = 1'b0; b0.addr_wr = '0; b0.data_wr = '0;
    b0.mark = 1'b0; b0.addr_mark = '0;
    b1.addr_rd = '0; b1.wr = 1'b0; b1.addr_wr = '0; b1.data_wr = '0;
    b1.mark = 1'b0; b1.addr_mark = '0;

    // Reset for three edges; reads point at x5 to prove they are forced to zero.
    b0.addr_rd = {5'd5, 5'd5, 5'd5, 5'd5};
    tick(); tick(); tick();
    chk("rst_ready", b0.ready, 0);
    chk("rst_busy", b0.busy_rd, 0);
    chk("rst_data", b0.data_rd, 0);

    // Clear with write and mark held on x20; both must be ignored.
    rst = 1'b0;
    b0.wr = 1'b1; b0.addr_wr = 5'd20; b0.data_wr = 32'hFFFF_FFFF;
    b0.mark = 1'b1; b0.addr_mark = 5'd20;
    b0.addr_rd = {5'd20, 5'd20, 5'd20, 5'd20};
    wait_ready(e0, e1, bad);
    b0.wr = 1'b0; b0.mark = 1'b0;
    #1;
    chk("clear_edges_32", e0, 31);
    chk("clear_edges_16", e1, 15);
    chk("clear_reads_zero", bad, 0);
    chk("clear_ignores_wr", b0.data_rd[31:0], 0);
    chk("clear_ignores_mark", b0.busy_rd[0], 0);

    // Writes visible next cycle on all ports.
    b0.wr = 1'b1; b0.addr_wr = 5'd5; b0.data_wr = 32'hDEAD_BEEF;
    tick();
    b0.addr_wr = 5'd31; b0.data_wr = 32'h1234_5678;
    tick();
    b0.wr = 1'b0;
    b0.addr_rd = {5'd31, 5'd5, 5'd5, 5'd5};
    #1;
    chk("rd_x5_p0", b0.data_rd[31:0], 32'hDEAD_BEEF);
    chk("rd_x5_p1", b0.data_rd[63:32], 32'hDEAD_BEEF);
    chk("rd_x5_p2", b0.data_rd[95:64], 32'hDEAD_BEEF);
    chk("rd_x31_p3", b0.data_rd[127:96], 32'h1234_5678);
    chk("rd_busy_idle", b0.busy_rd, 0);

    // Write to x0 has no effect.
    b0.wr = 1'b1; b0.addr_wr = 5'd0; b0.data_wr = 32'hFFFF_FFFF;
    tick();
    b0.wr = 1'b0;
    b0.addr_rd[4:0] = 5'd0;
    #1;
    chk("rd_x0", b0.data_rd[31:0], 0);

    // Same-cycle read of the address being written.
    b0.wr = 1'b1; b0.addr_wr = 5'd9; b0.data_wr = 32'h11;
    tick();
    b0.data_wr = 32'h55;
    b0.addr_rd[4:0] = 5'd9;
    #1;
    chk("byp_same_cycle", b0.data_rd[31:0], BYP_EXP);
    chk("byp_busy", b0.busy_rd[0], 0);
    tick();
    b0.wr = 1'b0;
    #1;
    chk("byp_next_cycle", b0.data_rd[31:0], 32'h55);

    // Scoreboard on x7 via port 1.
    b0.addr_rd[9:5] = 5'd7;
    b0.mark = 1'b1; b0.addr_mark = 5'd7;
    #1;
    chk("mark_same_cycle", b0.busy_rd[1], 0);
    tick();
    b0.mark = 1'b0;
    #1;
    chk("mark_busy", b0.busy_rd[1], 1);
    b0.wr = 1'b1; b0.addr_wr = 5'd7; b0.data_wr = 32'hABCD;
    b0.mark = 1'b1; b0.addr_mark = 5'd7;
    tick();
    b0.wr = 1'b0; b0.mark = 1'b0;
    #1;
    chk("wr_mark_busy", b0.busy_rd[1], 1);
    chk("wr_mark_data", b0.data_rd[63:32], 32'hABCD);
    b0.wr = 1'b1; b0.addr_wr = 5'd7; b0.data_wr = 32'h77;
    #1;
    chk("wr_busy_same_cycle", b0.busy_rd[1], BUSY7_EXP);
    tick();
    b0.wr = 1'b0;
    #1;
    chk("wr_clears_busy", b0.busy_rd[1], 0);
    chk("wr_x7_data", b0.data_rd[63:32], 32'h77);

    // Write and mark to different registers in one edge.
    b0.wr = 1'b1; b0.addr_wr = 5'd8; b0.data_wr = 32'h8;
    b0.mark = 1'b1; b0.addr_mark = 5'd10;
    tick();
    b0.wr = 1'b0; b0.mark = 1'b0;
    b0.addr_rd = {5'd31, 5'd5, 5'd10, 5'd8};
    #1;
    chk("diff_wr_data", b0.data_rd[31:0], 32'h8);
    chk("diff_wr_busy", b0.busy_rd[0], 0);
    chk("diff_mark_busy", b0.busy_rd[1], 1);

    // 16-register instance: x16 does not exist.
    b1.wr = 1'b1; b1.addr_wr = 5'd3; b1.data_wr = 32'h33;
    tick();
    b1.addr_wr = 5'd15; b1.data_wr = 32'h7;
    tick();
    b1.addr_wr = 5'd16; b1.data_wr = 32'hAAAA_5555;
    b1.mark = 1'b1; b1.addr_mark = 5'd16;
    tick();
    b1.wr = 1'b0; b1.mark = 1'b0;
    b1.addr_rd = 5'd16;
    #1;
    chk("r16_x16_data", b1.data_rd, 0);
    chk("r16_x16_busy", b1.busy_rd, 0);
    b1.addr_rd = 5'd15;
    #1;
    chk("r16_x15", b1.data_rd, 32'h7);
    b1.addr_rd = 5'd3;
    #1;
    chk("r16_x3", b1.data_rd, 32'h33);

    // Reset in RUN with x7 and x10 pending.
    b0.mark = 1'b1; b0.addr_mark = 5'd7;
    tick();
    b0.mark = 1'b0;
    b0.addr_rd = {5'd5, 5'd31, 5'd10, 5'd7};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rerst_ready", b0.ready, 0);
    chk("rerst_busy", b0.busy_rd, 0);
    wait_ready(e0, e1, bad);
    #1;
    chk("reclear_edges", e0, 31);
    chk("reclear_pending", b0.busy_rd, 0);
    for (int a = 0; a < 32; a++) begin
      b0.addr_rd[4:0] = a[4:0];
      #1;
      chk($sformatf("reclear_x%0d", a), b0.data_rd[31:0], 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_reg_file_sb.md
# cpu_reg_file_sb

Parametrised general-purpose register file for the CPU core: configurable data width, register count (16 or 32) and number of combinational read ports. It adds behaviour the basic register file lacks: a hardware clear sequence after reset, a per-register scoreboard of pending writes for hazard detection, and an optional write-to-read bypass. It sits between decode (reads, scoreboard marks) and writeback (writes).

## Interface

Parameters:
- XLEN, 32: register data width in bits.
- MORE_REGISTERS, 1'b1: 1 gives 32 registers (x0..x31); 0 gives 16 registers (x0..x15). REG_COUNT below means the resulting count.
- READ_PORTS, 2: number of independent read ports, 1..4.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready  out  1  high when the clear sequence is complete and the file accepts writes and marks.
- addr_rd  in  5*READ_PORTS  read addresses; port i is bits [5i+4:5i].
- data_rd  out  XLEN*READ_PORTS  read data; port i is bits [XLEN*i+XLEN-1:XLEN*i].
- busy_rd  out  READ_PORTS  port i high when register addr_rd[i] has a pending write.
- wr  in  1  write enable.
- addr_wr  in  5  write address.
- data_wr  in  XLEN  write data.
- mark  in  1  set the pending bit of addr_mark (instruction issued with that destination).
- addr_mark  in  5  destination register to mark.

## Operation

- Address validity: x0 and any address >= REG_COUNT are invalid for storage. An invalid read address returns data 0 and busy 0. Writes and marks to invalid addresses are ignored.
- State machine, two states:
  - CLEAR: entered on every edge with rst=1, which sets ptr=1 and clears all pending bits.
  - RUN: in CLEAR with rst=0, each edge writes regs[ptr]<=0. When ptr==REG_COUNT-1 the state moves to RUN; otherwise ptr increments.
- ready is 1 only in RUN.
- In CLEAR:
  - wr and mark are ignored.
  - data_rd reads 0 on every port.
  - busy_rd reads 0 on every port.
- Reset asserted mid-clear or in RUN restarts CLEAR from ptr=1.
- RUN write: on an edge with wr=1 and a valid addr_wr, regs[addr_wr]<=data_wr and pending[addr_wr]<=0.
- RUN mark: on an edge with mark=1 and a valid addr_mark, pending[addr_mark]<=1.
- Simultaneous write and mark to the same address: mark wins, so the pending bit ends at 1 while the data is still written. Different addresses: both take effect.
- Reads are combinational from the register array and pending bits. All ports are independent, and any ports may share an address.

## Timing

- Reset values: ready=0, busy_rd=0, data_rd=0. Register contents are undefined until the clear sequence finishes.
- Clear latency: ready rises after REG_COUNT-1 rising edges with rst=0, counting from the first edge at which rst is sampled low. That is 31 edges for 32 registers and 15 edges for 16.
- Write latency: a new value is visible on data_rd in the cycle after the write edge. busy_rd drops in the cycle after the write edge, and rises in the cycle after the mark edge.
- Same-cycle read of the address being written: see Configuration.

## Configuration

- CPU_REG_FILE_BYPASS_EN defined:
  - In RUN with wr=1, a read port whose valid address equals addr_wr outputs data_wr combinationally in the same cycle.
  - Its busy_rd is forced to 0 unless mark=1 to the same address in that cycle.
- CPU_REG_FILE_BYPASS_EN undefined: no bypass. Same-cycle reads return the old stored value and the current pending bit.

## Test plan

- Reset/clear, 32 registers: pulse rst for 3 cycles, then release. Required: ready=0 for exactly 31 edges, then 1. All ports read 0 throughout and busy_rd=0.
- Write/read, all ports: write 0xDEADBEEF to x5 and 0x12345678 to x31. Next cycle, all ports on x5 read 0xDEADBEEF and a port on x31 reads 0x12345678. A write to x0 leaves x0 reading 0.
- 16-register config: write 0xAAAA5555 to x16. Required: x16 reads 0 and x0..x15 are unchanged. Reading x15 after writing 7 to it returns 7.
- Scoreboard: mark x7, then the next cycle busy_rd=1 for x7. Then wr x7 together with mark x7 in the same cycle: busy stays 1 and data updates. A wr to x7 alone: busy=0 the next cycle.
- Bypass: with wr x9=0x55 and a same-cycle read of x9 holding old value 0x11. Required: 0x55 with the macro defined, 0x11 without it, and 0x55 the next cycle in both cases.
- Reset mid-operation: after several writes and marks, assert rst for 1 cycle. Required: ready drops and all busy bits clear. After re-clear (31 edges), every register reads 0.
